// File: rtl/clk_div_mc.sv
// rtl/clk_div_mc.sv - multi-channel integer clock divider with graceful stop, tick strobe and phase align
module clk_div_mc #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8
) (
    input  logic                      i_clk_ref,
    input  logic                      i_rst,
    input  logic [NUM_CH-1:0]         i_clk_en,
    input  logic [NUM_CH*WIDTH-1:0]   i_div_ratio,
    input  logic                      i_sync,
    output logic [NUM_CH-1:0]         o_div_clk,
    output logic [NUM_CH-1:0]         o_tick,
    output logic [NUM_CH-1:0]         o_active
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HIGH   = 2'd1;
    localparam logic [1:0] ST_LOW    = 2'd2;
    localparam logic [1:0] ST_BYPASS = 2'd3;

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            logic [1:0]       state_q, state_d;
            logic [WIDTH-1:0] cnt_q, cnt_d;
            logic [WIDTH-1:0] shadow_q, shadow_d;
            logic             div_clk_q, div_clk_d;
            logic             tick_q, tick_d;
            logic             active_q, active_d;

            logic [WIDTH-1:0] ratio;
            logic [WIDTH-1:0] high_len;
            logic [WIDTH-1:0] low_len;
            logic             en;
            logic             ratio_ok;
            logic             running;
            logic             do_start;
            logic             do_stop;
            logic             do_bypass;

            assign ratio    = i_div_ratio[c*WIDTH +: WIDTH];
            assign en       = i_clk_en[c];
            assign ratio_ok = (ratio >= WIDTH'(2));
            assign running  = (state_q == ST_HIGH) || (state_q == ST_LOW);
            // High phase is the floor half; an odd ratio lengthens the low phase.
            assign high_len = shadow_q >> 1;
            assign low_len  = shadow_q - high_len;

            // Next-state decode: sync restart outranks normal phase stepping.
            always_comb begin
                state_d   = state_q;
                cnt_d     = cnt_q;
                shadow_d  = shadow_q;
                div_clk_d = div_clk_q;
                tick_d    = 1'b0;
                active_d  = active_q;
                do_start  = 1'b0;
                do_stop   = 1'b0;
                do_bypass = 1'b0;

                if (i_sync && running) begin
                    if (en && ratio_ok) begin
                        do_start = 1'b1;
                    end else begin
                        do_stop = 1'b1;
                    end
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (en) begin
                                if (ratio_ok) begin
                                    do_start = 1'b1;
                                end else begin
                                    do_bypass = 1'b1;
                                end
                            end
                        end
                        ST_HIGH: begin
                            if (cnt_q == high_len) begin
                                state_d   = ST_LOW;
                                div_clk_d = 1'b0;
                                cnt_d     = WIDTH'(1);
                            end else begin
                                cnt_d = cnt_q + WIDTH'(1);
                            end
                        end
                        ST_LOW: begin
                            // Period boundary: only here are enable and ratio re-sampled.
                            if (cnt_q == low_len) begin
                                if (!en) begin
                                    do_stop = 1'b1;
                                end else if (ratio_ok) begin
                                    do_start = 1'b1;
                                end else begin
                                    do_bypass = 1'b1;
                                end
                            end else begin
                                cnt_d = cnt_q + WIDTH'(1);
                            end
                        end
                        ST_BYPASS: begin
                            if (!en) begin
                                do_stop = 1'b1;
                            end else if (ratio_ok) begin
                                do_start = 1'b1;
                            end
                        end
                        default: begin
                            do_stop = 1'b1;
                        end
                    endcase
                end

                if (do_start) begin
                    state_d   = ST_HIGH;
                    shadow_d  = ratio;
                    cnt_d     = WIDTH'(1);
                    div_clk_d = 1'b1;
                    tick_d    = 1'b1;
                    active_d  = 1'b1;
                end
                if (do_stop) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    div_clk_d = 1'b0;
                    active_d  = 1'b0;
                end
                if (do_bypass) begin
                    state_d   = ST_BYPASS;
                    cnt_d     = '0;
                    div_clk_d = 1'b0;
                    active_d  = 1'b0;
                end
            end

            // Channel state registers with synchronous reset.
            always_ff @(posedge i_clk_ref) begin
                if (i_rst) begin
                    state_q   <= ST_IDLE;
                    cnt_q     <= '0;
                    shadow_q  <= '0;
                    div_clk_q <= 1'b0;
                    tick_q    <= 1'b0;
                    active_q  <= 1'b0;
                end else begin
                    state_q   <= state_d;
                    cnt_q     <= cnt_d;
                    shadow_q  <= shadow_d;
                    div_clk_q <= div_clk_d;
                    tick_q    <= tick_d;
                    active_q  <= active_d;
                end
            end

            // Bypass is the only combinational clock path; all other modes use registers.
            assign o_div_clk[c] = (state_q == ST_BYPASS) ? i_clk_ref : div_clk_q;
            assign o_tick[c]    = (state_q == ST_BYPASS) ? 1'b1 : tick_q;
            assign o_active[c]  = active_q;
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_mc.sv
// tb/tb_clk_div_mc.sv - directed scoreboard bench for clk_div_mc
module tb_clk_div_mc;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 8;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     sync;
    logic [NUM_CH-1:0]        en;
    logic [NUM_CH*WIDTH-1:0]  ratio;
    logic [NUM_CH-1:0]        div_clk;
    logic [NUM_CH-1:0]        tick;
    logic [NUM_CH-1:0]        active;

    typedef struct {
        int         cyc;
        int         ch;
        logic [2:0] val;
        string      tag;
    } exp_t;

    exp_t              sb[$];
    int                cyc        = 0;
    int                n_pass     = 0;
    int                n_total    = 0;
    logic [NUM_CH-1:0] probe_mask = '0;

    clk_div_mc #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
        .i_clk_ref   (clk),
        .i_rst       (rst),
        .i_clk_en    (en),
        .i_div_ratio (ratio),
        .i_sync      (sync),
        .o_div_clk   (div_clk),
        .o_tick      (tick),
        .o_active    (active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] want);
        n_total++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, want);
    endtask

    task automatic push(input int off, input int ch, input logic dc, input logic tk,
                        input logic ac, input string tag);
        exp_t e;
        e.cyc = cyc + off;
        e.ch  = ch;
        e.val = {dc, tk, ac};
        e.tag = tag;
        sb.push_back(e);
    endtask

    // one divided period: h high cycles, tick on the first, n cycles total
    task automatic push_period(input int off, input int ch, input int h, input int n,
                               input string tag);
        for (int i = 0; i < n; i++) begin
            push(off + i, ch, (i < h), (i == 0), 1'b1, tag);
        end
    endtask

    task automatic step();
        exp_t keep[$];
        @(posedge clk);
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (probe_mask[c]) begin
                check($sformatf("bypass_high_ch%0d_c%0d", c, cyc + 1),
                      {2'b00, div_clk[c]}, 3'b001);
            end
        end
        @(negedge clk);
        cyc++;
        foreach (sb[i]) begin
            if (sb[i].cyc == cyc) begin
                check($sformatf("%s_ch%0d_c%0d", sb[i].tag, sb[i].ch, cyc),
                      {div_clk[sb[i].ch], tick[sb[i].ch], active[sb[i].ch]}, sb[i].val);
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    endtask

    task automatic set_ratio(input int ch, input int r);
        ratio[ch*WIDTH +: WIDTH] = r[WIDTH-1:0];
    endtask

    task automatic do_reset();
        en  = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        sync  = 1'b0;
        en    = '0;
        ratio = '0;

        // reset state
        for (int c = 0; c < NUM_CH; c++) push(1, c, 1'b0, 1'b0, 1'b0, "reset");
        step();
        rst = 1'b0;

        // ch0 R=4: 1,1,0,0 repeating
        set_ratio(0, 4);
        en = 4'b0001;
        for (int k = 0; k < 3; k++) push_period(1 + 4 * k, 0, 2, 4, "div4");
        repeat (12) step();

        // ch1 R=5, change to R=2 during HIGH
        do_reset();
        set_ratio(1, 5);
        en = 4'b0010;
        push_period(1, 1, 2, 5, "div5");
        for (int k = 0; k < 4; k++) push_period(6 + 2 * k, 1, 1, 2, "div2");
        step();
        set_ratio(1, 2);
        repeat (12) step();

        // ch2 R=6, drop enable in 2nd high cycle: graceful stop
        do_reset();
        set_ratio(2, 6);
        en = 4'b0100;
        push_period(1, 2, 3, 6, "div6");
        for (int i = 7; i <= 10; i++) push(i, 2, 1'b0, 1'b0, 1'b0, "stopped");
        repeat (2) step();
        en = 4'b0000;
        repeat (8) step();

        // ch3 bypass with R=1, then R=3
        do_reset();
        set_ratio(3, 1);
        en = 4'b1000;
        probe_mask = 4'b1000;
        for (int i = 1; i <= 3; i++) push(i, 3, 1'b0, 1'b1, 1'b0, "bypass");
        repeat (3) step();
        probe_mask = '0;
        set_ratio(3, 3);
        for (int k = 0; k < 2; k++) push_period(1 + 3 * k, 3, 1, 3, "div3");
        repeat (6) step();

        // sync aligns ch0 R=4 and ch1 R=8 started out of phase
        do_reset();
        set_ratio(0, 4);
        set_ratio(1, 8);
        en = 4'b0001;
        step();
        en = 4'b0011;
        repeat (3) step();
        sync = 1'b1;
        for (int k = 0; k < 4; k++) push_period(1 + 4 * k, 0, 2, 4, "sync_div4");
        for (int k = 0; k < 2; k++) push_period(1 + 8 * k, 1, 4, 8, "sync_div8");
        step();
        sync = 1'b0;
        repeat (15) step();

        // reset mid-HIGH with all channels running, then restart with en held
        do_reset();
        set_ratio(0, 4);
        set_ratio(1, 5);
        set_ratio(2, 6);
        set_ratio(3, 3);
        en = 4'b1111;
        step();
        rst = 1'b1;
        for (int c = 0; c < NUM_CH; c++) push(1, c, 1'b0, 1'b0, 1'b0, "mid_reset");
        step();
        rst = 1'b0;
        push_period(1, 0, 2, 4, "restart");
        push_period(1, 1, 2, 5, "restart");
        push_period(1, 2, 3, 6, "restart");
        push_period(1, 3, 1, 3, "restart");
        repeat (6) step();

        check("scoreboard_drained", {2'b00, (sb.size() == 0)}, 3'b001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
